// File: rtl/display_pkg.sv
// display_pkg: pixel layout constants and serial-word to RGBA4444 expansion shared by display stream blocks
package display_pkg;
   localparam int COLOR_R_POS           = 12;
   localparam int COLOR_G_POS           = 8;
   localparam int COLOR_B_POS           = 4;
   localparam int COLOR_A_POS           = 0;
   localparam int COLOR_SUB_PIXEL_WIDTH = 4;
   localparam int RGB565_R_MSB          = 15;
   localparam int RGB565_G_MSB          = 10;
   localparam int RGB565_B_MSB          = 4;
   localparam int WORD_WIDTH_RGB565     = 16;
   localparam int WORD_WIDTH_RGB444     = 12;

   typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

   // RGB565 keeps the top 4 bits of each channel; RGB444 maps straight through
   function automatic logic [15:0] expand_word(input logic [15:0] w, input logic is565, input logic [3:0] alpha);
      logic [15:0] p;
      p = '0;
      p[COLOR_R_POS +: COLOR_SUB_PIXEL_WIDTH] = is565 ? w[RGB565_R_MSB -: 4] : w[11:8];
      p[COLOR_G_POS +: COLOR_SUB_PIXEL_WIDTH] = is565 ? w[RGB565_G_MSB -: 4] : w[7:4];
      p[COLOR_B_POS +: COLOR_SUB_PIXEL_WIDTH] = is565 ? w[RGB565_B_MSB -: 4] : w[3:0];
      p[COLOR_A_POS +: COLOR_SUB_PIXEL_WIDTH] = alpha;
      return p;
   endfunction
endpackage

// File: rtl/axis_skid_fifo2.sv
// axis_skid_fifo2: two-entry stream buffer (head + skid) carrying data and last; push while full without pop is ignored
module axis_skid_fifo2 #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   output logic              o_full,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last
);
   logic              r_head_v, r_head_l, r_skid_v, r_skid_l;
   logic [DATA_W-1:0] r_head_d, r_skid_d;
   logic              w_pop;

   assign w_pop   = r_head_v && i_ready;
   assign o_full  = r_skid_v;
   assign o_valid = r_head_v;
   assign o_data  = r_head_d;
   assign o_last  = r_head_l;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_head_v <= 1'b0;
         r_head_l <= 1'b0;
         r_head_d <= '0;
         r_skid_v <= 1'b0;
         r_skid_l <= 1'b0;
         r_skid_d <= '0;
      end else if (w_pop && r_skid_v) begin
         r_head_d <= r_skid_d;
         r_head_l <= r_skid_l;
         r_skid_v <= i_push;
         if (i_push) begin
            r_skid_d <= i_data;
            r_skid_l <= i_last;
         end
      end else if (w_pop || !r_head_v) begin
         r_head_v <= i_push;
         if (i_push) begin
            r_head_d <= i_data;
            r_head_l <= i_last;
         end
      end else if (!r_skid_v && i_push) begin
         r_skid_v <= 1'b1;
         r_skid_d <= i_data;
         r_skid_l <= i_last;
      end
   end
endmodule

// File: rtl/spi_pixel_receiver.sv
// spi_pixel_receiver: SPI mode-0 slave that oversamples sck/mosi/csn in clk, assembles
// RGB565/RGB444 words MSB first and streams RGBA4444 pixels on AXI-Stream with per-frame tlast.
module spi_pixel_receiver
   import display_pkg::*;
#(
   parameter int         PIXEL      = 16384,
   parameter int         WORD_WIDTH = 16,
   parameter logic [3:0] ALPHA_FILL = 4'hF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sck,
   input  logic        mosi,
   input  logic        csn,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [15:0] m_axis_tdata,
   output logic        overflow,
   input  logic        clearOverflow,
   output logic        receiving
);
   localparam int CNT_W = $clog2(WORD_WIDTH);
   localparam int PIX_W = $clog2(PIXEL) + 1;

   logic [1:0]            r_sck_s, r_mosi_s, r_csn_s;
   logic                  r_sck_prev, r_overflow, r_receiving;
   rx_state_t             r_state;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [WORD_WIDTH-2:0] r_shift;
   logic [PIX_W-1:0]      r_pix_cnt;
   logic                  w_sample, w_done, w_last, w_full, w_drop;
   logic [15:0]           w_word, w_pixel;

   assign w_sample  = (r_state == RX_SHIFT) && !r_csn_s[1] && r_sck_s[1] && !r_sck_prev;
   assign w_done    = w_sample && (r_bit_cnt == CNT_W'(WORD_WIDTH - 1));
   assign w_word    = 16'({r_shift, r_mosi_s[1]});
   assign w_pixel   = expand_word(w_word, WORD_WIDTH == WORD_WIDTH_RGB565, ALPHA_FILL);
   assign w_last    = r_pix_cnt == PIX_W'(PIXEL - 1);
   assign w_drop    = w_done && w_full && !(m_axis_tvalid && m_axis_tready);
   assign overflow  = r_overflow;
   assign receiving = r_receiving;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sck_s     <= 2'b00;
         r_mosi_s    <= 2'b00;
         r_csn_s     <= 2'b11;
         r_sck_prev  <= 1'b0;
         r_state     <= RX_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_receiving <= 1'b0;
         r_pix_cnt   <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_sck_s    <= {r_sck_s[0], sck};
         r_mosi_s   <= {r_mosi_s[0], mosi};
         r_csn_s    <= {r_csn_s[0], csn};
         r_sck_prev <= r_sck_s[1];
         if (r_csn_s[1]) begin
            r_state     <= RX_IDLE;
            r_bit_cnt   <= '0;
            r_receiving <= 1'b0;
         end else begin
            r_state <= RX_SHIFT;
            if (w_sample) begin
               r_shift     <= w_word[WORD_WIDTH-2:0];
               r_bit_cnt   <= w_done ? '0 : r_bit_cnt + 1'b1;
               r_receiving <= !w_done;
            end
         end
         // dropped words still count so frame alignment survives an overflow
         if (w_done) r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
         r_overflow <= w_drop || (r_overflow && !clearOverflow);
      end
   end

   axis_skid_fifo2 #(.DATA_W(16)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_done),
      .i_data  (w_pixel),
      .i_last  (w_last),
      .o_full  (w_full),
      .i_ready (m_axis_tready),
      .o_valid (m_axis_tvalid),
      .o_data  (m_axis_tdata),
      .o_last  (m_axis_tlast)
   );
endmodule

// File: tb/tb_spi_pixel_receiver.sv
// tb_spi_pixel_receiver: scoreboard bench driving a 16-bit and a 12-bit receiver (PIXEL=4) with directed SPI words
module tb_spi_pixel_receiver;
   logic        clk = 1'b0, resetn = 1'b0;
   logic        sck16 = 1'b0, mosi16 = 1'b0, csn16 = 1'b1, rdy16 = 1'b1, clr16 = 1'b0;
   logic        sck12 = 1'b0, mosi12 = 1'b0, csn12 = 1'b1, rdy12 = 1'b1, clr12 = 1'b0;
   logic        v16, l16, ov16, rx16, v12, l12, ov12, rx12;
   logic [15:0] d16, d12;
   logic [16:0] q16[$], q12[$];
   logic [16:0] e16, e12;
   int          n_cmp = 0, n_err = 0, idx16 = 0, idx12 = 0;
   logic        tog = 1'b0;

   always #5 clk = ~clk;

   spi_pixel_receiver #(.PIXEL(4), .WORD_WIDTH(16), .ALPHA_FILL(4'hF)) u16 (
      .clk(clk), .resetn(resetn), .sck(sck16), .mosi(mosi16), .csn(csn16),
      .m_axis_tvalid(v16), .m_axis_tready(rdy16), .m_axis_tlast(l16), .m_axis_tdata(d16),
      .overflow(ov16), .clearOverflow(clr16), .receiving(rx16));

   spi_pixel_receiver #(.PIXEL(4), .WORD_WIDTH(12), .ALPHA_FILL(4'hF)) u12 (
      .clk(clk), .resetn(resetn), .sck(sck12), .mosi(mosi12), .csn(csn12),
      .m_axis_tvalid(v12), .m_axis_tready(rdy12), .m_axis_tlast(l12), .m_axis_tdata(d12),
      .overflow(ov12), .clearOverflow(clr12), .receiving(rx12));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] model16(input logic [15:0] w);
      return {w[15:12], w[10:7], w[4:1], 4'hF};
   endfunction

   task automatic expect16(input logic [15:0] px, input bit keep);
      logic l;
      l = (idx16 == 3);
      idx16 = l ? 0 : idx16 + 1;
      if (keep) q16.push_back({l, px});
   endtask

   task automatic expect12(input logic [15:0] px);
      logic l;
      l = (idx12 == 3);
      idx12 = l ? 0 : idx12 + 1;
      q12.push_back({l, px});
   endtask

   task automatic spi_bits(input bit b12, input int n, input logic [15:0] w);
      for (int i = n - 1; i >= 0; i--) begin
         if (b12) mosi12 = w[i]; else mosi16 = w[i];
         #40;
         if (b12) sck12 = 1'b1; else sck16 = 1'b1;
         #40;
         if (b12) sck12 = 1'b0; else sck16 = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q16.size() != 0 || q12.size() != 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("drain pending", 32'(q16.size() + q12.size()), 0);
      repeat (2) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (resetn && v16 && rdy16) begin
         if (q16.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL u16 unexpected: got %h expected none", d16);
         end else begin
            e16 = q16.pop_front();
            chk("u16 {tlast,tdata}", 32'({l16, d16}), 32'(e16));
         end
      end
      if (resetn && v12 && rdy12) begin
         if (q12.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL u12 unexpected: got %h expected none", d12);
         end else begin
            e12 = q12.pop_front();
            chk("u12 {tlast,tdata}", 32'({l12, d12}), 32'(e12));
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (tog) rdy16 = ~rdy16;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst tvalid", 32'({v16, v12}), 0);
      chk("rst tdata16", 32'(d16), 0);
      chk("rst tlast", 32'({l16, l12}), 0);
      chk("rst overflow", 32'({ov16, ov12}), 0);
      chk("rst receiving", 32'({rx16, rx12}), 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      csn16 = 1'b0;
      #40;
      spi_bits(0, 7, 16'h005A);
      repeat (4) @(negedge clk);
      chk("receiving mid-word", 32'(rx16), 1);
      resetn = 1'b0;
      q16.delete(); q12.delete(); idx16 = 0; idx12 = 0;
      @(negedge clk);
      chk("mid-word rst receiving", 32'(rx16), 0);
      chk("mid-word rst tvalid", 32'(v16), 0);
      chk("mid-word rst overflow", 32'(ov16), 0);
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      expect16(16'hAB2F, 1); spi_bits(0, 16, 16'hA5A5);
      expect16(16'hF0FF, 1); spi_bits(0, 16, 16'hF81F);
      expect16(16'h0F0F, 1); spi_bits(0, 16, 16'h07E0);
      drain();
      chk("tvalid after drain", 32'(v16), 0);
      spi_bits(0, 9, 16'h01FF);
      csn16 = 1'b1;
      repeat (4) @(negedge clk);
      chk("receiving after csn abort", 32'(rx16), 0);
      csn16 = 1'b0;
      #40;
      expect16(16'h14AF, 1); spi_bits(0, 16, 16'h1234);
      drain();
      @(posedge clk); #1 rdy16 = 1'b0;
      expect16(16'hFFFF, 1); spi_bits(0, 16, 16'hFFFF);
      expect16(16'h000F, 1); spi_bits(0, 16, 16'h0000);
      expect16(16'h0000, 0); spi_bits(0, 16, 16'h8421);
      repeat (6) @(negedge clk);
      chk("overflow on drop", 32'(ov16), 1);
      chk("held tvalid", 32'(v16), 1);
      chk("held tdata", 32'(d16), 32'h0000FFFF);
      @(posedge clk); #1 rdy16 = 1'b1;
      drain();
      chk("overflow sticky", 32'(ov16), 1);
      @(posedge clk); #1 clr16 = 1'b1;
      @(posedge clk); #1 clr16 = 1'b0;
      @(negedge clk);
      chk("overflow cleared", 32'(ov16), 0);
      tog = 1'b1;
      for (int k = 0; k < 8; k++) begin
         logic [15:0] r;
         r = 16'($urandom);
         expect16(model16(r), 1);
         spi_bits(0, 16, r);
      end
      drain();
      tog = 1'b0;
      @(posedge clk); #1 rdy16 = 1'b1;
      @(negedge clk);
      chk("no overflow under stall", 32'(ov16), 0);
      csn12 = 1'b0;
      #40;
      expect12(16'hA5CF); spi_bits(1, 12, 16'h0A5C);
      expect12(16'h123F); spi_bits(1, 12, 16'h0123);
      expect12(16'hFFFF); spi_bits(1, 12, 16'h0FFF);
      expect12(16'h000F); spi_bits(1, 12, 16'h0000);
      expect12(16'h7E1F); spi_bits(1, 12, 16'h07E1);
      drain();
      chk("u12 overflow", 32'(ov12), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
